// File: rtl/fan_tach_monitor.sv
// Fan tachometer monitor: synchronizes and glitch-filters the tach line,
// then reports per-window RPM, the period between pulses and a stall flag.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high reset
//   tach       raw open-drain tach input (asynchronous, idle-high)
//   fan_pwm    PWM drive applied to the fan (used only with the mask option)
//   rpm        RPM of the last completed window, saturating at 65535
//   rpm_valid  one-cycle strobe when rpm updates
//   period     clocks between the last two accepted falling edges, saturating
//   stall      no accepted edge for STALL_CYCLES clocks
//
// Optional feature macro: FAN_TACH_PWM_MASK_EN
//   When defined, the tach filter is frozen while fan_pwm is low and for
//   FILTER_CYCLES clocks after it returns high (3-wire fans lose tach when
//   undriven). When undefined, fan_pwm is ignored.

module fan_tach_monitor #(
    parameter int CLOCK_FREQ_HZ  = 100000000,
    parameter int PULSES_PER_REV = 2,
    parameter int WINDOW_CYCLES  = CLOCK_FREQ_HZ,
    parameter int FILTER_CYCLES  = 16,
    parameter int STALL_CYCLES   = CLOCK_FREQ_HZ / 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tach,
    input  logic        fan_pwm,
    output logic [15:0] rpm,
    output logic        rpm_valid,
    output logic [27:0] period,
    output logic        stall
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_ONE   = WIN_W'(1);
    localparam logic [7:0]       FILT_LAST = 8'(FILTER_CYCLES - 1);
    localparam logic [27:0]      STALL_LAST = 28'(STALL_CYCLES - 1);
    localparam logic [21:0]      RPM_K     = 22'(60 / PULSES_PER_REV);
    localparam logic [27:0]      SE_MAX    = '1;

    logic             tach_s1_q, tach_s1_d;
    logic             tach_s2_q, tach_s2_d;
    logic             filt_q, filt_d;
    logic [7:0]       filt_cnt_q, filt_cnt_d;
    logic [27:0]      since_q, since_d;
    logic [27:0]      period_q, period_d;
    logic             first_q, first_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [15:0]      edge_cnt_q, edge_cnt_d;
    logic [15:0]      rpm_q, rpm_d;
    logic             rpm_valid_q, rpm_valid_d;
    logic             stall_q, stall_d;

    logic             mask;
    logic             edge_evt;
    logic             win_term;
    logic [27:0]      since_inc;
    logic [15:0]      n_edges;
    logic [21:0]      rpm_prod;

`ifdef FAN_TACH_PWM_MASK_EN
    logic       pwm_s1_q, pwm_s1_d;
    logic       pwm_s2_q, pwm_s2_d;
    logic [7:0] hold_q, hold_d;

    // hold_q reloads while drive is off and counts down the settle time
    // after drive returns, so the tach has FILTER_CYCLES to recover.
    always_comb begin
        pwm_s1_d = fan_pwm;
        pwm_s2_d = pwm_s1_q;
        hold_d   = hold_q;
        if (!pwm_s2_q) begin
            hold_d = 8'(FILTER_CYCLES);
        end else if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
        end
        mask = !pwm_s2_q || (hold_q != 8'd0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_s1_q <= 1'b1;
            pwm_s2_q <= 1'b1;
            hold_q   <= 8'd0;
        end else begin
            pwm_s1_q <= pwm_s1_d;
            pwm_s2_q <= pwm_s2_d;
            hold_q   <= hold_d;
        end
    end
`else
    logic unused_fan_pwm;
    assign unused_fan_pwm = fan_pwm;
    assign mask = 1'b0;
`endif

    always_comb begin
        tach_s1_d = tach;
        tach_s2_d = tach_s1_q;

        // Counter runs only while the synced sample disagrees with the
        // accepted level; the level flips on the FILTER_CYCLES-th sample.
        filt_d     = filt_q;
        filt_cnt_d = 8'd0;
        if (!mask && (tach_s2_q != filt_q)) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_d = ~filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 8'd1;
            end
        end
        edge_evt = filt_q && !filt_d;

        since_inc = (since_q == SE_MAX) ? SE_MAX : since_q + 28'd1;
        since_d   = edge_evt ? 28'd0 : since_inc;

        period_d = period_q;
        first_d  = first_q;
        if (edge_evt) begin
            first_d = 1'b1;
            if (first_q) begin
                period_d = since_inc;
            end
        end

        // Edge count includes an edge landing on the terminal cycle.
        n_edges = (edge_evt && (edge_cnt_q != 16'hFFFF))
                ? edge_cnt_q + 16'd1 : edge_cnt_q;
        win_term = (win_q == WIN_LAST);
        rpm_prod = 22'(n_edges) * RPM_K;

        rpm_d       = rpm_q;
        rpm_valid_d = win_term;
        win_d       = win_term ? '0 : win_q + WIN_ONE;
        edge_cnt_d  = win_term ? 16'd0 : n_edges;
        if (win_term) begin
            rpm_d = (rpm_prod > 22'd65535) ? 16'hFFFF : rpm_prod[15:0];
        end

        stall_d = edge_evt ? 1'b0
                : ((since_q >= STALL_LAST) ? 1'b1 : stall_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tach_s1_q   <= 1'b1;
            tach_s2_q   <= 1'b1;
            filt_q      <= 1'b1;
            filt_cnt_q  <= 8'd0;
            since_q     <= 28'd0;
            period_q    <= 28'd0;
            first_q     <= 1'b0;
            win_q       <= '0;
            edge_cnt_q  <= 16'd0;
            rpm_q       <= 16'd0;
            rpm_valid_q <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            tach_s1_q   <= tach_s1_d;
            tach_s2_q   <= tach_s2_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            since_q     <= since_d;
            period_q    <= period_d;
            first_q     <= first_d;
            win_q       <= win_d;
            edge_cnt_q  <= edge_cnt_d;
            rpm_q       <= rpm_d;
            rpm_valid_q <= rpm_valid_d;
            stall_q     <= stall_d;
        end
    end

    assign rpm       = rpm_q;
    assign rpm_valid = rpm_valid_q;
    assign period    = period_q;
    assign stall     = stall_q;

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Directed table-driven bench for fan_tach_monitor
// (WINDOW=1000, FILTER=4, STALL=500, PULSES_PER_REV=2).

module tb_fan_tach_monitor;

    localparam int M_RST    = 0;
    localparam int M_IDLE   = 1;
    localparam int M_WAVE   = 2;
    localparam int M_GLITCH = 3;
    localparam int M_PULSE4 = 4;
    localparam int M_PWM    = 5;

`ifdef FAN_TACH_PWM_MASK_EN
    localparam int PWM_RPM = 300;
    localparam int PWM_PER = 100;
`else
    localparam int PWM_RPM = 600;
    localparam int PWM_PER = 40;
`endif

    typedef struct {
        string name;
        int    mode;
        int    cycles;
        int    period;
        int    stall;
        int    rv;
        int    nvalid;
        int    rpm;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        tach;
    logic        fan_pwm;
    logic [15:0] rpm;
    logic        rpm_valid;
    logic [27:0] period;
    logic        stall;

    int cyc;
    int nvalid;
    int checks;
    int errors;

    vec_t vecs[$];

    fan_tach_monitor #(
        .CLOCK_FREQ_HZ (100000000),
        .PULSES_PER_REV(2),
        .WINDOW_CYCLES (1000),
        .FILTER_CYCLES (4),
        .STALL_CYCLES  (500)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .tach     (tach),
        .fan_pwm  (fan_pwm),
        .rpm      (rpm),
        .rpm_valid(rpm_valid),
        .period   (period),
        .stall    (stall)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        cyc = cyc + 1;
        if (rpm_valid) nvalid = nvalid + 1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        tach    = 1'b1;
        fan_pwm = 1'b1;
        repeat (5) tick();
        reset  = 1'b0;
        cyc    = 0;
        nvalid = 0;
    endtask

    task automatic drive(input int mode, input int c);
        int m100;
        int m50;
        m100    = c % 100;
        m50     = c % 50;
        fan_pwm = 1'b1;
        case (mode)
            M_WAVE:   tach = (m100 < 50);
            M_GLITCH: tach = !(m50 >= 20 && m50 < 23);
            M_PULSE4: tach = !(c >= 1100 && c < 1104);
            M_PWM: begin
                fan_pwm = !(m100 >= 10 && m100 < 30);
                tach    = fan_pwm ? (m100 < 50) : 1'b0;
            end
            default:  tach = 1'b1;
        endcase
    endtask

    task automatic check(input string vn, input string what,
                         input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s.%s: got %0d expected %0d", vn, what, act, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        tach    = 1'b1;
        fan_pwm = 1'b1;
        cyc     = 0;
        nvalid  = 0;
        checks  = 0;
        errors  = 0;

        //                name           mode      cyc  per  st rv nv rpm
        vecs.push_back('{"rst_a",        M_RST,      0,   0, 0, 0, 0,   0});
        vecs.push_back('{"idle_499",     M_IDLE,   499,   0, 0, 0, 0,   0});
        vecs.push_back('{"stall_500",    M_IDLE,     1,   0, 1, 0, 0,   0});
        vecs.push_back('{"idle_999",     M_IDLE,   499,   0, 1, 0, 0,   0});
        vecs.push_back('{"win1_idle",    M_IDLE,     1,   0, 1, 1, 1,   0});
        vecs.push_back('{"strobe_off",   M_IDLE,     1,   0, 1, 0, 1,   0});
        vecs.push_back('{"rst_b",        M_RST,      0,   0, 0, 0, 0,   0});
        vecs.push_back('{"wave_100",     M_WAVE,   100,   0, 0, 0, 0,   0});
        vecs.push_back('{"wave_200",     M_WAVE,   100, 100, 0, 0, 0,   0});
        vecs.push_back('{"wave_w1",      M_WAVE,   800, 100, 0, 1, 1, 300});
        vecs.push_back('{"wave_w2",      M_WAVE,  1000, 100, 0, 1, 2, 300});
        vecs.push_back('{"gap_2455",     M_IDLE,   455, 100, 0, 0, 2, 300});
        vecs.push_back('{"gap_2456",     M_IDLE,     1, 100, 1, 0, 2, 300});
        vecs.push_back('{"gap_w3",       M_IDLE,   544, 100, 1, 1, 3,   0});
        vecs.push_back('{"restart_3055", M_WAVE,    55, 100, 1, 0, 3,   0});
        vecs.push_back('{"restart_3056", M_WAVE,     1,1100, 0, 0, 3,   0});
        vecs.push_back('{"wave_w4",      M_WAVE,   944, 100, 0, 1, 4, 300});
        vecs.push_back('{"mid_4600",     M_WAVE,   600, 100, 0, 0, 4, 300});
        vecs.push_back('{"rst_c",        M_RST,      0,   0, 0, 0, 0,   0});
        vecs.push_back('{"post_999",     M_WAVE,   999, 100, 0, 0, 0,   0});
        vecs.push_back('{"post_w1",      M_WAVE,     1, 100, 0, 1, 1, 300});
        vecs.push_back('{"rst_d",        M_RST,      0,   0, 0, 0, 0,   0});
        vecs.push_back('{"glitch_499",   M_GLITCH, 499,   0, 0, 0, 0,   0});
        vecs.push_back('{"glitch_500",   M_GLITCH,   1,   0, 1, 0, 0,   0});
        vecs.push_back('{"glitch_w1",    M_GLITCH, 500,   0, 1, 1, 1,   0});
        vecs.push_back('{"pulse_1105",   M_PULSE4, 105,   0, 1, 0, 1,   0});
        vecs.push_back('{"pulse_1106",   M_PULSE4,   1,   0, 0, 0, 1,   0});
        vecs.push_back('{"rst_e",        M_RST,      0,   0, 0, 0, 0,   0});
        vecs.push_back('{"pwm_w1",       M_PWM,   1000, PWM_PER, 0, 1, 1, PWM_RPM});

        foreach (vecs[i]) begin
            if (vecs[i].mode == M_RST) begin
                do_reset();
            end else begin
                for (int k = 0; k < vecs[i].cycles; k++) begin
                    drive(vecs[i].mode, cyc);
                    tick();
                end
            end
            check(vecs[i].name, "period", int'(period), vecs[i].period);
            check(vecs[i].name, "stall", int'(stall), vecs[i].stall);
            check(vecs[i].name, "rpm_valid", int'(rpm_valid), vecs[i].rv);
            check(vecs[i].name, "n_valid", nvalid, vecs[i].nvalid);
            check(vecs[i].name, "rpm", int'(rpm), vecs[i].rpm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fan_tach_monitor.md
Name: fan_tach_monitor

Overview:
Measures fan speed from the open-drain tachometer line and closes the loop around the PWM fan controller. It synchronizes and glitch-filters the tach input, then produces three results:
- per-window RPM
- period between tach pulses, in clocks
- stall flag

It sits beside the fan PWM block in the board support logic, on the same 100 MHz clock. Its outputs feed status registers and the alarm logic.

Parameters:
CLOCK_FREQ_HZ, 100000000, clock frequency; informational only, used for default derivation.
PULSES_PER_REV, 2, tach falling edges per fan revolution; must divide 60 (1, 2, 3, 4, 5, 6).
WINDOW_CYCLES, 100000000, RPM gate window length in clocks (1 s).
FILTER_CYCLES, 16, consecutive stable samples required to accept a tach level change; 1..255.
STALL_CYCLES, 20000000, clocks without an accepted edge before stall asserts; < 2^28.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
tach  input  1  raw fan tachometer, asynchronous, idle-high
fan_pwm  input  1  PWM drive currently applied to the fan; used only with FAN_TACH_PWM_MASK_EN
rpm  output  16  RPM of the last completed window, saturating at 65535
rpm_valid  output  1  one-cycle strobe when rpm updates
period  output  28  clocks between the last two accepted falling edges, saturating
stall  output  1  no accepted edge for STALL_CYCLES clocks

Behaviour:
Reset (reset=1 at a clock edge):
- rpm=0, rpm_valid=0, period=0, stall=0.
- Filtered level=1, filter counter=0, window counter=0, edge counter=0, since_edge=0, first-edge flag cleared.
- Reset asserted mid-window discards the partial window; no rpm_valid is issued.

Synchronizer and filter:
- tach passes through a 2-flop synchronizer.
- The filter counter increments while the synced sample differs from the filtered level. It clears when they match.
- When the counter reaches FILTER_CYCLES, the filtered level flips and the counter clears.
- A pulse shorter than FILTER_CYCLES clocks is never accepted.

Edge event:
- Filtered level 1->0 gives a one-cycle edge event.
- Latency from tach transition to edge: 2 + FILTER_CYCLES clocks.

Period:
- since_edge is 28 bits, saturating.
- Each cycle: if edge, since_edge<=0; else since_edge<=since_edge+1.
- On an edge with first-edge flag set: period<=sat(since_edge+1). Edges at cycles t0 and t1 therefore give period = t1-t0.
- The first edge after reset only sets the flag; period stays 0.

Window:
- The window counter runs 0..WINDOW_CYCLES-1 and wraps.
- The edge counter is 16-bit, saturating.
- At the terminal count, n = edges in the window, including an edge in that same cycle:
  - rpm <= min(n*60/PULSES_PER_REV, 65535), computed as a constant multiply with 22-bit intermediate.
  - rpm_valid=1 for exactly that one following cycle.
  - The edge counter restarts at 0.
- First rpm_valid occurs WINDOW_CYCLES cycles after reset release.

Stall:
- stall <= edge ? 0 : (since_edge >= STALL_CYCLES-1 ? 1 : stall).
- With no edges after reset, stall rises at cycle STALL_CYCLES.
- stall clears the cycle after any edge.
- stall is independent of the window; rpm reads 0 naturally when stalled.

Optional Feature:
FAN_TACH_PWM_MASK_EN:
- Defined: fan_pwm is synchronized with 2 flops.
  - While synced fan_pwm=0, and for FILTER_CYCLES clocks after it returns to 1, the filter counter is held at 0 and the filtered level is frozen. No edges are produced.
  - since_edge and the stall check still run.
  - This avoids false edges from 3-wire fans whose tach collapses when drive is removed.
- Undefined: fan_pwm is ignored; the port remains present and unconnected internally.

Test Plan:
Test-bench parameters for all scenarios: WINDOW_CYCLES=1000, FILTER_CYCLES=4, STALL_CYCLES=500, PULSES_PER_REV=2.
1. Reset held 5 cycles, tach=1 -> rpm=0, period=0, stall=0, rpm_valid=0; first rpm_valid at cycle 1000 with rpm=0.
2. tach square wave, 100-cycle period, 50% duty, steady -> period=100 after the 2nd edge; each window with 10 edges gives rpm=300 with a one-cycle rpm_valid.
3. tach=1 with 3-cycle low glitches every 50 cycles -> no edges; rpm=0, period unchanged; stall=1 by cycle 500.
4. 100-cycle wave, then tach held 1 -> stall=1 exactly 500 cycles after the last edge; restart the wave -> stall=0 the cycle after the first edge; period saturates/reflects the gap (e.g. 800).
5. Reset asserted at window cycle 600 after 6 edges -> no rpm_valid for that window; next window starts from 0; rpm=0 until first post-reset window completes.
6. (FAN_TACH_PWM_MASK_EN) fan_pwm toggling low for 20 cycles with tach forced low during low phases, genuine 100-cycle tach otherwise -> only genuine edges counted, rpm=300; without the macro, extra edges are counted and rpm > 300.
